vending_controller: RTL and testbench
=====================================

VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter TIMEOUT, default 200, gives the idle cycles allowed in COLLECT before an automatic refund.
REQ-002 Parameter CW, default 8, gives the width of credit and change.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sel_valid  input  1  high while any product button is pressed; sel_code is sampled only when this is high.
REQ-006 sel_code  input  3  product code 0-7 from the priority encoder; it may be Z when sel_valid is low.
REQ-007 coin_valid  input  1  one-cycle pulse per inserted coin.
REQ-008 coin_type  input  2  coin value: 00=1, 01=5, 10=10, 11=20.
REQ-009 cancel  input  1  level input; a high sample aborts the purchase.
REQ-010 dispense  output  1  one-cycle pulse; the product is released.
REQ-011 product  output  3  latched product code, valid while dispense is high.
REQ-012 change_valid  output  1  one-cycle pulse; change holds the amount to return.
REQ-013 change  output  CW  amount to return; 0 whenever change_valid is low.
REQ-014 refund  output  1  high together with change_valid when the purchase was aborted.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 credit  output  CW  running credit, for the display.

Function
REQ-017 The block has five states, encoded in 3 bits: IDLE, COLLECT, DISPENSE, CHANGE, REFUND.
REQ-018 IDLE: when sel_valid=1, the block latches sel_code into product, clears credit, clears the timeout counter, and moves to COLLECT on the next cycle. Coins arriving in IDLE are ignored and no credit is taken.
REQ-019 COLLECT: sel_valid is ignored, so the selection is locked once taken.
REQ-020 COLLECT: each coin_valid pulse adds the coin value to credit and clears the timeout counter; credit saturates at 2^CW-1.
REQ-021 COLLECT: when the next-cycle credit is >= PRICE[product], the next state is DISPENSE; the check includes the coin arriving this cycle.
REQ-022 COLLECT: cancel=1 moves the block to REFUND. A coin in the same cycle is still added to credit. Cancel has priority over reaching the price.
REQ-023 COLLECT: the timeout counter increments each cycle with no coin; reaching TIMEOUT-1 moves the block to REFUND.
REQ-024 DISPENSE lasts exactly one cycle: dispense=1 and the change register is loaded with credit-PRICE[product]. The next state is CHANGE if the difference is nonzero, otherwise IDLE.
REQ-025 CHANGE lasts one cycle: change_valid=1, refund=0, and change holds the difference. Credit clears on exit and the next state is IDLE.
REQ-026 REFUND lasts one cycle: change_valid=1, refund=1, and change equals credit. If credit is 0, change_valid stays 0 and refund still pulses. Credit clears on exit and the next state is IDLE.
REQ-027 Latency: from the final qualifying coin to dispense is 1 cycle, and dispense to change_valid is 1 cycle.
REQ-028 All outputs are registered, with no combinational path from inputs to outputs.
REQ-029 An X or Z on sel_code while sel_valid=0 never propagates into the state.

Reset
REQ-030 Asserting rst at any time, including mid-purchase, forces state=IDLE, credit=0, change=0, product=0, timeout counter=0, and dispense=change_valid=refund=busy=0. Inserted credit is forfeited.
REQ-031 The first rising edge after rst deasserts evaluates the inputs normally.

Structure
REQ-032 A shared package vending_pkg holds the state enumeration, the coin value constants (1, 5, 10, 20), and the PRICE table: codes 0-7 = 10, 15, 20, 25, 30, 35, 40, 50.
REQ-033 One sub-module, price_lut, is combinational and maps the 3-bit product code to a CW-bit price; the controller instantiates it once.

Verification
REQ-034 Exact payment: select code 2 (price 20), then coins 10 and 10 -> dispense pulse 1 cycle after the second coin with product=2, no change_valid, return to IDLE.
REQ-035 Overpay: select code 0 (price 10), then coin 20 -> dispense, then next cycle change_valid=1, change=10, refund=0.
REQ-036 Cancel with a simultaneous coin: select code 7 (price 50), coin 20, then cancel together with coin 5 -> REFUND with change=25 and refund=1, and no dispense.
REQ-037 Timeout: with TIMEOUT=16, select code 3 and insert coin 5, then apply no activity -> refund with change=5 16 cycles after the coin.
REQ-038 Reset mid-purchase: select code 4 and insert coin 10, then assert rst between clock edges -> all outputs 0 immediately and busy=0, and a later selection starts with credit=0.
REQ-039 Lockout: during COLLECT for code 1, press sel_valid with code 6 and insert coins totalling 15 -> product=1 is dispensed, and coins in IDLE leave credit at 0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// coin denominations and the per-product price table.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_REFUND   = 3'd4
  } state_e;

  localparam int unsigned COIN_VAL_1  = 32'd1;
  localparam int unsigned COIN_VAL_5  = 32'd5;
  localparam int unsigned COIN_VAL_10 = 32'd10;
  localparam int unsigned COIN_VAL_20 = 32'd20;

  localparam int unsigned PRICE [8] = '{32'd10, 32'd15, 32'd20, 32'd25,
                                        32'd30, 32'd35, 32'd40, 32'd50};

  function automatic int unsigned coin_value(input logic [1:0] coin_type);
    int unsigned val;
    case (coin_type)
      2'b00:   val = COIN_VAL_1;
      2'b01:   val = COIN_VAL_5;
      2'b10:   val = COIN_VAL_10;
      2'b11:   val = COIN_VAL_20;
      default: val = 32'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Front-panel bundle between the machine panel (master) and the vending
// controller (slave): selection, coin and cancel in; dispense/change status out.
interface vending_controller_if #(
  parameter int CW = 8
);
  logic          sel_valid;
  logic [2:0]    sel_code;
  logic          coin_valid;
  logic [1:0]    coin_type;
  logic          cancel;
  logic          dispense;
  logic [2:0]    product;
  logic          change_valid;
  logic [CW-1:0] change;
  logic          refund;
  logic          busy;
  logic [CW-1:0] credit;

  modport master (
    output sel_valid, sel_code, coin_valid, coin_type, cancel,
    input  dispense, product, change_valid, change, refund, busy, credit
  );

  modport slave (
    input  sel_valid, sel_code, coin_valid, coin_type, cancel,
    output dispense, product, change_valid, change, refund, busy, credit
  );
endinterface

// File: rtl/price_lut.sv
// Combinational product-code to price lookup, sized to the credit width.
module price_lut
  import vending_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [2:0]    code,
  output logic [CW-1:0] price
);

  // Decode the product code into its catalogue price.
  always_comb begin
    case (code)
      3'd0:    price = CW'(PRICE[0]);
      3'd1:    price = CW'(PRICE[1]);
      3'd2:    price = CW'(PRICE[2]);
      3'd3:    price = CW'(PRICE[3]);
      3'd4:    price = CW'(PRICE[4]);
      3'd5:    price = CW'(PRICE[5]);
      3'd6:    price = CW'(PRICE[6]);
      3'd7:    price = CW'(PRICE[7]);
      default: price = '0;
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// Vending machine purchase FSM: take a selection, collect coins, dispense and
// return change, or refund on cancel/timeout. All panel outputs are registered.
module vending_controller
  import vending_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  vending_controller_if.slave   bus
);

  localparam int          CW1      = CW + 1;
  localparam int          TMO_W    = $clog2(TIMEOUT) + 1;
  localparam [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_r;
  logic [2:0]       product_r;
  logic [CW-1:0]    credit_r;
  logic [CW-1:0]    diff_r;
  logic [CW-1:0]    change_r;
  logic [TMO_W-1:0] tmo_r;
  logic             dispense_r;
  logic             change_valid_r;
  logic             refund_r;
  logic             busy_r;

  logic [CW-1:0]    price_s;
  logic [CW:0]      sum_s;
  logic [CW-1:0]    credit_next_s;
  logic             timeout_s;

  price_lut #(.CW(CW)) u_price_lut (
    .code  (product_r),
    .price (price_s)
  );

  // Credit after this cycle's coin, saturating at the top of the range.
  always_comb begin
    if (bus.coin_valid) begin
      sum_s = {1'b0, credit_r} + CW1'(coin_value(bus.coin_type));
    end else begin
      sum_s = {1'b0, credit_r};
    end
    if (sum_s[CW]) begin
      credit_next_s = '1;
    end else begin
      credit_next_s = sum_s[CW-1:0];
    end
    timeout_s = (!bus.coin_valid) && (tmo_r == TMO_LAST);
  end

  // Purchase state machine with registered panel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      product_r      <= 3'd0;
      credit_r       <= '0;
      diff_r         <= '0;
      change_r       <= '0;
      tmo_r          <= '0;
      dispense_r     <= 1'b0;
      change_valid_r <= 1'b0;
      refund_r       <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      dispense_r     <= 1'b0;
      change_valid_r <= 1'b0;
      refund_r       <= 1'b0;
      change_r       <= '0;
      case (state_r)
        ST_IDLE: begin
          // sel_code is only looked at while a button is actually pressed
          if (bus.sel_valid) begin
            product_r <= bus.sel_code;
            credit_r  <= '0;
            tmo_r     <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_COLLECT;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_COLLECT: begin
          credit_r <= credit_next_s;
          if (bus.coin_valid) begin
            tmo_r <= '0;
          end else if (tmo_r != TMO_LAST) begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
          // Cancel and timeout win over reaching the price in the same cycle.
          if (bus.cancel || timeout_s) begin
            refund_r       <= 1'b1;
            change_valid_r <= (credit_next_s != '0);
            change_r       <= credit_next_s;
            state_r        <= ST_REFUND;
          end else if (credit_next_s >= price_s) begin
            dispense_r <= 1'b1;
            diff_r     <= credit_next_s - price_s;
            state_r    <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (diff_r != '0) begin
            change_valid_r <= 1'b1;
            change_r       <= diff_r;
            state_r        <= ST_CHANGE;
          end else begin
            credit_r <= '0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_CHANGE, ST_REFUND: begin
          credit_r <= '0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          credit_r <= '0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dispense     = dispense_r;
  assign bus.product      = product_r;
  assign bus.change_valid = change_valid_r;
  assign bus.change       = change_r;
  assign bus.refund       = refund_r;
  assign bus.busy         = busy_r;
  assign bus.credit       = credit_r;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: exact pay, overpay, cancel, timeout,
// asynchronous reset mid-purchase and selection lockout.
module tb_vending_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   early_refund;

  vending_controller_if #(.CW(8)) vif ();

  vending_controller #(.TIMEOUT(16), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.sel_valid  = 1'b0;
    vif.sel_code   = 3'bzzz;
    vif.coin_valid = 1'b0;
    vif.coin_type  = 2'b00;
    vif.cancel     = 1'b0;
  endtask

  task automatic select(input logic [2:0] code);
    vif.sel_valid = 1'b1;
    vif.sel_code  = code;
    tick();
    idle_inputs();
  endtask

  task automatic coin(input logic [1:0] t);
    vif.coin_valid = 1'b1;
    vif.coin_type  = t;
    tick();
    vif.coin_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    early_refund = 0;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_busy", vif.busy, 0);
    check("rst_credit", vif.credit, 0);
    check("rst_dispense", vif.dispense, 0);
    check("rst_change_valid", vif.change_valid, 0);
    check("rst_change", vif.change, 0);
    check("rst_product", vif.product, 0);
    rst = 1'b0;

    // Exact payment: code 2 (20), coins 10 + 10
    select(3'd2);
    check("exact_busy", vif.busy, 1);
    check("exact_product_latch", vif.product, 2);
    coin(2'b10);
    check("exact_credit10", vif.credit, 10);
    check("exact_no_early_dispense", vif.dispense, 0);
    coin(2'b10);
    check("exact_dispense", vif.dispense, 1);
    check("exact_product", vif.product, 2);
    tick();
    check("exact_dispense_1cyc", vif.dispense, 0);
    check("exact_no_change", vif.change_valid, 0);
    check("exact_idle", vif.busy, 0);

    // Overpay: code 0 (10), coin 20 -> change 10
    select(3'd0);
    coin(2'b11);
    check("over_dispense", vif.dispense, 1);
    check("over_change_zero_early", vif.change, 0);
    tick();
    check("over_change_valid", vif.change_valid, 1);
    check("over_change", vif.change, 10);
    check("over_refund", vif.refund, 0);
    tick();
    check("over_change_valid_off", vif.change_valid, 0);
    check("over_change_cleared", vif.change, 0);
    check("over_credit_cleared", vif.credit, 0);
    check("over_idle", vif.busy, 0);

    // Cancel with a simultaneous coin: code 7 (50), coin 20, then cancel + coin 5
    select(3'd7);
    coin(2'b11);
    check("cancel_credit20", vif.credit, 20);
    vif.cancel = 1'b1;
    coin(2'b01);
    vif.cancel = 1'b0;
    check("cancel_refund", vif.refund, 1);
    check("cancel_change_valid", vif.change_valid, 1);
    check("cancel_change", vif.change, 25);
    check("cancel_no_dispense", vif.dispense, 0);
    tick();
    check("cancel_refund_off", vif.refund, 0);
    check("cancel_idle", vif.busy, 0);
    check("cancel_credit_cleared", vif.credit, 0);

    // Timeout: code 3, coin 5, then refund exactly 16 cycles after the coin
    select(3'd3);
    coin(2'b01);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (vif.refund !== 1'b0) early_refund++;
    end
    check("tmo_no_early_refund", early_refund, 0);
    tick();
    check("tmo_refund", vif.refund, 1);
    check("tmo_change_valid", vif.change_valid, 1);
    check("tmo_change", vif.change, 5);
    tick();
    check("tmo_idle", vif.busy, 0);

    // Reset between clock edges mid-purchase
    select(3'd4);
    coin(2'b10);
    check("rstmid_credit10", vif.credit, 10);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_busy", vif.busy, 0);
    check("rstmid_credit", vif.credit, 0);
    check("rstmid_product", vif.product, 0);
    check("rstmid_dispense", vif.dispense, 0);
    check("rstmid_change_valid", vif.change_valid, 0);
    tick();
    rst = 1'b0;
    select(3'd5);
    check("rstmid_new_credit", vif.credit, 0);
    check("rstmid_new_product", vif.product, 5);
    // Cancel with zero credit: refund pulses, no change_valid
    vif.cancel = 1'b1;
    tick();
    vif.cancel = 1'b0;
    check("zero_refund", vif.refund, 1);
    check("zero_change_valid", vif.change_valid, 0);
    check("zero_change", vif.change, 0);
    tick();

    // Lockout: code 1 (15), sel code 6 pressed during COLLECT
    select(3'd1);
    vif.sel_valid = 1'b1;
    vif.sel_code  = 3'd6;
    coin(2'b10);
    check("lock_product", vif.product, 1);
    check("lock_credit10", vif.credit, 10);
    coin(2'b01);
    idle_inputs();
    check("lock_dispense", vif.dispense, 1);
    check("lock_dispense_product", vif.product, 1);
    tick();
    check("lock_idle", vif.busy, 0);
    vif.sel_code = 3'bxxx;
    coin(2'b11);
    check("idle_coin_credit", vif.credit, 0);
    check("idle_coin_busy", vif.busy, 0);
    check("idle_x_product", vif.product, 1);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
